int_mul_div: RTL and testbench

- Iterative unsigned 16-bit multiply/divide unit downstream of the 8x16 register file.
- Consumes the two read-port operands R and S, and produces a 32-bit result (hi/lo halves) that the control unit writes back through the register file's W port over two write cycles.
- Shares the single datapath clock and holds its result until the next operation starts.

---
 rtl/int_mul_div.sv | 157 +++++++++++++++
 tb/tb_int_mul_div.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/int_mul_div.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One iteration per clock; result held on Y_hi/Y_lo until the next accepted start.
module int_mul_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             div0
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_hi_q, y_hi_d;
  logic [WIDTH-1:0]   y_lo_q, y_lo_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;

  logic               accept;
  logic               div_by_zero;
  logic               last_iter;
  logic [2*WIDTH-1:0] step;

  // Shift-add: conditional add into the upper half with carry, then the whole
  // {carry, hi, lo} chain moves right one place.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] mcand
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + ({(WIDTH+1){lo[0]}} & {1'b0, mcand});
    return {sum, lo[WIDTH-1:1]};
  endfunction

  // Restoring step: shift {rem, quot} left, try subtracting the divisor,
  // keep the difference only when it does not go negative.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quot,
    input logic [WIDTH-1:0] dvsr
  );
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    rem_sh = {rem, quot[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, dvsr};
    if (trial[WIDTH+1:WIDTH] != 2'b00) begin
      return {rem_sh[WIDTH-1:0], quot[WIDTH-2:0], 1'b0};
    end
    return {trial[WIDTH-1:0], quot[WIDTH-2:0], 1'b1};
  endfunction

  assign accept      = start && (state_q != S_RUN);
  assign div_by_zero = op && (S == '0);
  assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
  assign step        = op_q ? div_step(hi_q, lo_q, opnd_q) : mul_step(hi_q, lo_q, opnd_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = div_by_zero ? S_DONE : S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = start ? (div_by_zero ? S_DONE : S_RUN) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    y_hi_d = y_hi_q;
    y_lo_d = y_lo_q;
    div0_d = div0_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    op_d   = op_q;
    if (accept) begin
      // MUL keeps the multiplicand aside and shifts the multiplier through lo;
      // DIV keeps the divisor aside and shifts the dividend through lo.
      opnd_d = op ? S : R;
      lo_d   = op ? R : S;
      hi_d   = '0;
      op_d   = op;
      cnt_d  = '0;
      div0_d = 1'b0;
      if (div_by_zero) begin
        y_hi_d = R;
        y_lo_d = '1;
        div0_d = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      {hi_d, lo_d} = step;
      cnt_d        = cnt_q + 1'b1;
      if (last_iter) begin
        {y_hi_d, y_lo_d} = step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      y_hi_q <= '0;
      y_lo_q <= '0;
      div0_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      y_hi_q <= y_hi_d;
      y_lo_q <= y_lo_d;
      div0_q <= div0_d;
    end
  end

  // Working registers are always reloaded at an accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
    op_q   <= op_d;
  end

  assign Y_hi = y_hi_q;
  assign Y_lo = y_lo_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_int_mul_div.sv
// Bench for int_mul_div: cycle-level reference model plus directed and random operations.
module tb_int_mul_div;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] R;
  logic [W-1:0] S;
  logic         busy;
  logic         done;
  logic [W-1:0] Y_hi;
  logic [W-1:0] Y_lo;
  logic         div0;

  int checks = 0;
  int errors = 0;

  int_mul_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .R     (R),
    .S     (S),
    .busy  (busy),
    .done  (done),
    .Y_hi  (Y_hi),
    .Y_lo  (Y_lo),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op finishes WIDTH edges later (or on the same
  // edge for divide-by-zero) with the arithmetically exact result.
  int           k = 0;
  int           busy_until = -1;
  int           done_at = -1;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_div0 = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [31:0]  prod;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_until = -1;
      done_at    = -1;
      m_hi       = '0;
      m_lo       = '0;
      m_div0     = 1'b0;
      m_busy     = 1'b0;
      m_done     = 1'b0;
    end else begin
      k++;
      if (k == done_at) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      if (start && !m_busy) begin
        m_div0 = 1'b0;
        if (op && S == 0) begin
          m_hi       = R;
          m_lo       = '1;
          m_div0     = 1'b1;
          done_at    = k;
          busy_until = k;
        end else begin
          if (op) begin
            p_lo = R / S;
            p_hi = R % S;
          end else begin
            prod = R * S;
            p_hi = prod[31:16];
            p_lo = prod[15:0];
          end
          done_at    = k + W;
          busy_until = k + W;
        end
      end
      m_busy = (k < busy_until);
      m_done = (k == done_at);
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("busy_and_done", {31'd0, busy & done}, 32'd0);
    chk("Y_hi", {16'd0, Y_hi}, {16'd0, m_hi});
    chk("Y_lo", {16'd0, Y_lo}, {16'd0, m_lo});
    chk("div0", {31'd0, div0}, {31'd0, m_div0});
  end

  task automatic run_op(input logic o, input logic [W-1:0] r, input logic [W-1:0] s,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                        input int exp_lat, input int repulse_at, input string name);
    int n;
    int nb;
    @(negedge clk);
    start = 1'b1; op = o; R = r; S = s;
    @(negedge clk);
    start = 1'b0; R = W'($urandom); S = W'($urandom);
    n  = 1;
    nb = busy ? 1 : 0;
    while (!done && n < 60) begin
      if (n == repulse_at) begin
        start = 1'b1; R = W'($urandom); S = W'($urandom) | 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (busy) nb++;
    end
    start = 1'b0;
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_busy_cycles"}, nb, exp_lat - 1);
    chk({name, "_hi"}, {16'd0, Y_hi}, {16'd0, eh});
    chk({name, "_lo"}, {16'd0, Y_lo}, {16'd0, el});
    chk({name, "_div0"}, {31'd0, div0}, {31'd0, ed});
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 1'b0; R = '0; S = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", {16'd0, Y_hi}, 32'd0);
    chk("rst_lo", {16'd0, Y_lo}, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17, -1, "mul_1234_5678");
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, -1, "mul_ffff_ffff");
    run_op(1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 17, -1, "mul_zero");
    run_op(1'b1, 16'd1000, 16'd7,    16'h0006, 16'h008E, 1'b0, 17, -1, "div_1000_7");
    run_op(1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17, -1, "div_5_9");
    run_op(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17, -1, "div_ffff_1");
    run_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1,  -1, "div_by_zero");
    run_op(1'b0, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 1'b0, 17, -1, "mul_3_4");
    run_op(1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 17, 5,  "mul_repulse");

    // Back-to-back: start held during the DONE cycle launches the next op at once.
    @(negedge clk);
    start = 1'b1; op = 1'b0; R = 16'd3; S = 16'd5;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", n, 17);
    chk("b2b_first_lo", {16'd0, Y_lo}, 32'h0000_000F);
    start = 1'b1; op = 1'b1; R = 16'd1000; S = 16'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_latency", n, 17);
    chk("b2b_second_hi", {16'd0, Y_hi}, 32'h0000_0006);
    chk("b2b_second_lo", {16'd0, Y_lo}, 32'h0000_008E);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 1'b0; R = 16'h1234; S = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", {16'd0, Y_hi}, 32'd0);
    chk("midrst_lo", {16'd0, Y_lo}, 32'd0);
    chk("midrst_div0", {31'd0, div0}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_op(1'b0, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 1'b0, 17, -1, "after_reset");

    // Random traffic: pulses land in every state, operands change every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 4) == 0);
      op    = 1'($urandom_range(0, 1));
      R     = W'($urandom);
      S     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
